// File: rtl/spi_pkg.sv
// Shared types for the SPI daisy-chain master: the latched SPI mode and the frame FSM states.
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// sclk generator: one half-period tick every CLK_DIV enabled cycles, plus leading/trailing strobes.
// Strobes are asserted in the cycle before sclk changes; no backpressure, counter is held at 0 while disabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  input  logic cpol,
  input  logic cpol_next,
  output logic half_stb,
  output logic lead_stb,
  output logic trail_stb,
  output logic sclk
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    tick   = 1'b0;
    if (!en) begin
      // Idle level tracks the mode that will be latched, so a new CPOL is visible from the first LEAD cycle.
      div_d  = '0;
      sclk_d = cpol_next;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      tick  = 1'b1;
      if (toggle_en) begin
        sclk_d = ~sclk_q;
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign half_stb  = tick;
  assign lead_stb  = tick & toggle_en & (sclk_q == cpol);
  assign trail_stb = tick & toggle_en & (sclk_q != cpol);
  assign sclk      = sclk_q;

endmodule

// File: rtl/spi_chain_master.sv
// SPI master for a daisy chain of NUM_DEV devices sharing one ss_n; shifts NUM_DEV*WIDTH bits MSB first.
// done arrives 1+CLK_DIV*(2*TOTAL+1) cycles after start; start is ignored while ready is low.
module spi_chain_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_DEV = 3,
  parameter int CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [NUM_DEV*WIDTH-1:0] tx_data,
  output logic                     ready,
  output logic                     done,
  output logic [NUM_DEV*WIDTH-1:0] rx_data,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     ss_n
);

  localparam int TOTAL = NUM_DEV * WIDTH;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(TOTAL - 1);

  spi_state_t         state_q, state_d;
  spi_mode_t          mode_q, mode_d;
  logic [TOTAL-1:0]   tx_sr_q, tx_sr_d;
  logic [TOTAL-1:0]   rx_sr_q, rx_sr_d;
  logic [TOTAL-1:0]   rx_data_q, rx_data_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic               mosi_q, mosi_d;
  logic               ss_n_q, ss_n_d;
  logic               done_q, done_d;

  logic div_en, toggle_en, cpol_next;
  logic half_stb, lead_stb, trail_stb;

  assign div_en    = (state_q != IDLE);
  assign toggle_en = (state_q == LEAD) || (state_q == SHIFT);
  assign cpol_next = (state_q == IDLE && start) ? mode[1] : mode_q.cpol;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk      (clk),
    .rst      (rst),
    .en       (div_en),
    .toggle_en(toggle_en),
    .cpol     (mode_q.cpol),
    .cpol_next(cpol_next),
    .half_stb (half_stb),
    .lead_stb (lead_stb),
    .trail_stb(trail_stb),
    .sclk     (sclk)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LEAD;
          mode_d    = mode;
          ss_n_d    = 1'b0;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          // CPHA=0 must drive the MSB before the first edge; CPHA=1 presents it on the first leading edge.
          if (mode[0]) begin
            mosi_d  = 1'b0;
            tx_sr_d = tx_data;
          end else begin
            mosi_d  = tx_data[TOTAL-1];
            tx_sr_d = tx_data << 1;
          end
        end
      end
      LEAD: begin
        if (lead_stb) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (trail_stb && bit_cnt_q == LAST_BIT) begin
          state_d = TRAIL;
        end
      end
      TRAIL: begin
        if (half_stb) begin
          state_d   = IDLE;
          ss_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (lead_stb) begin
      if (mode_q.cpha) begin
        mosi_d  = tx_sr_q[TOTAL-1];
        tx_sr_d = tx_sr_q << 1;
      end else begin
        rx_sr_d = (rx_sr_q << 1) | TOTAL'(miso);
      end
    end

    if (trail_stb) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (mode_q.cpha) begin
        rx_sr_d = (rx_sr_q << 1) | TOTAL'(miso);
      end else if (bit_cnt_q != LAST_BIT) begin
        mosi_d  = tx_sr_q[TOTAL-1];
        tx_sr_d = tx_sr_q << 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_chain_master.sv
// Directed bench: 3x8 chain at CLK_DIV=4 against a shift-register chain model, plus a 1x8 chain at CLK_DIV=1.
module tb_spi_chain_master;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int T  = N * W;
  localparam int CD = 4;
  localparam int DONE_CYC = 1 + CD * (2 * T + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [T-1:0] tx_data;
  logic         ready, done, sclk, mosi, miso, ss_n;
  logic [T-1:0] rx_data;

  logic         s_start;
  logic [1:0]   s_mode;
  logic [W-1:0] s_tx;
  logic         s_ready, s_done, s_sclk, s_mosi, s_ss_n;
  logic         s_miso;
  logic [W-1:0] s_rx;

  int n_vec = 0;
  int n_err = 0;

  spi_chain_master #(.WIDTH(W), .NUM_DEV(N), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .tx_data(tx_data),
    .ready(ready), .done(done), .rx_data(rx_data), .sclk(sclk),
    .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  spi_chain_master #(.WIDTH(8), .NUM_DEV(1), .CLK_DIV(1)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .tx_data(s_tx),
    .ready(s_ready), .done(s_done), .rx_data(s_rx), .sclk(s_sclk),
    .mosi(s_mosi), .miso(s_miso), .ss_n(s_ss_n)
  );

  // Chain model: the whole daisy chain behaves as one T-bit shift register.
  logic [T-1:0] chain_q   = '0;
  logic [T-1:0] pre_val   = '0;
  logic         load_req  = 1'b0;
  logic         cap_q     = 1'b0;
  logic         out_q     = 1'b0;
  logic         sclk_prev = 1'b0;
  logic         ss_prev   = 1'b1;
  logic         m_cpol    = 1'b0;
  logic         m_cpha    = 1'b0;

  assign miso = m_cpha ? out_q : chain_q[T-1];

  always @(negedge clk) begin
    if (load_req) begin
      chain_q = pre_val;
      cap_q   = 1'b0;
      out_q   = 1'b0;
    end else if (!ss_n && !ss_prev && sclk !== sclk_prev) begin
      if (sclk_prev == m_cpol) begin
        if (m_cpha) out_q = chain_q[T-1];
        else        cap_q = mosi;
      end else begin
        chain_q = {chain_q[T-2:0], (m_cpha ? mosi : cap_q)};
      end
    end
    sclk_prev = sclk;
    ss_prev   = ss_n;
  end

  task automatic preload(input logic [T-1:0] v);
    pre_val  = v;
    load_req = 1'b1;
    @(negedge clk);
    #1 load_req = 1'b0;
  endtask

  // Caller must be positioned just after a rising edge: this cycle becomes cycle 0.
  task automatic start_frame(input logic [T-1:0] tx, input logic [1:0] md);
    m_cpol  = md[1];
    m_cpha  = md[0];
    tx_data = tx;
    mode    = md;
    start   = 1'b1;
  endtask

  task automatic wait_done(input bit toggle, output int dcyc, output logic m1, output logic me,
                           output logic s1, output logic se, output logic q1);
    dcyc = -1; m1 = 1'bx; me = 1'bx; s1 = 1'bx; se = 1'bx; q1 = 1'bx;
    for (int c = 1; c <= DONE_CYC + 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin m1 = mosi; s1 = sclk; q1 = ss_n; end
      if (c == 1 + CD) begin me = mosi; se = sclk; end
      if (done) begin dcyc = c; start = 1'b0; break; end
      start = toggle ? (c % 2 == 1) : 1'b0;
      if (toggle) begin
        mode    = 2'b11;
        tx_data = ~tx_data;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (ready !== 1'b1)   begin n_err++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_vec++; if (done !== 1'b0)    begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_vec++; if (ss_n !== 1'b1)    begin n_err++; $display("FAIL rst_ss_n: got %b want 1", ss_n); end
    n_vec++; if (sclk !== 1'b0)    begin n_err++; $display("FAIL rst_sclk: got %b want 0", sclk); end
    n_vec++; if (mosi !== 1'b0)    begin n_err++; $display("FAIL rst_mosi: got %b want 0", mosi); end
    n_vec++; if (rx_data !== '0)   begin n_err++; $display("FAIL rst_rx: got %h want 0", rx_data); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_mode0();
    int dc; logic m1, me, s1, se, q1;
    preload(24'h123456);
    @(posedge clk); #1;
    start_frame(24'hA5C33C, 2'b00);
    wait_done(1'b0, dc, m1, me, s1, se, q1);
    n_vec++; if (dc != 197)            begin n_err++; $display("FAIL m0_done_cyc: got %0d want 197", dc); end
    n_vec++; if (rx_data !== 24'h123456) begin n_err++; $display("FAIL m0_rx: got %h want 123456", rx_data); end
    n_vec++; if (chain_q !== 24'hA5C33C) begin n_err++; $display("FAIL m0_chain: got %h want a5c33c", chain_q); end
    n_vec++; if (m1 !== 1'b1)          begin n_err++; $display("FAIL m0_mosi_c1: got %b want 1", m1); end
    n_vec++; if (q1 !== 1'b0)          begin n_err++; $display("FAIL m0_ss_c1: got %b want 0", q1); end
    n_vec++; if (s1 !== 1'b0 || se !== 1'b1) begin n_err++; $display("FAIL m0_sclk: got idle %b edge %b want 0 1", s1, se); end
    n_vec++; if (ready !== 1'b1 || ss_n !== 1'b1) begin n_err++; $display("FAIL m0_end: got ready %b ss_n %b want 1 1", ready, ss_n); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0)        begin n_err++; $display("FAIL m0_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_modes();
    int dc; logic m1, me, s1, se, q1;
    logic [1:0] md;
    for (int m = 1; m <= 3; m++) begin
      md = 2'(m);
      preload(24'h123456);
      @(posedge clk); #1;
      start_frame(24'hA5C33C, md);
      wait_done(1'b0, dc, m1, me, s1, se, q1);
      n_vec++; if (dc != 197) begin n_err++; $display("FAIL mode%0d_done_cyc: got %0d want 197", m, dc); end
      n_vec++; if (rx_data !== 24'h123456) begin n_err++; $display("FAIL mode%0d_rx: got %h want 123456", m, rx_data); end
      n_vec++; if (chain_q !== 24'hA5C33C) begin n_err++; $display("FAIL mode%0d_chain: got %h want a5c33c", m, chain_q); end
      n_vec++; if (s1 !== md[1] || se !== ~md[1]) begin n_err++; $display("FAIL mode%0d_sclk: got idle %b edge %b want %b %b", m, s1, se, md[1], ~md[1]); end
      n_vec++; if (sclk !== md[1]) begin n_err++; $display("FAIL mode%0d_sclk_idle_end: got %b want %b", m, sclk, md[1]); end
      if (md[0]) begin
        n_vec++; if (m1 !== 1'b0 || me !== 1'b1) begin n_err++; $display("FAIL mode%0d_mosi_first: got %b then %b want 0 then 1", m, m1, me); end
      end else begin
        n_vec++; if (m1 !== 1'b1) begin n_err++; $display("FAIL mode%0d_mosi_c1: got %b want 1", m, m1); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc; logic m1, me, s1, se, q1;
    preload(24'h123456);
    @(posedge clk); #1;
    start_frame(24'hA5C33C, 2'b00);
    wait_done(1'b0, dc, m1, me, s1, se, q1);
    n_vec++; if (dc != 197 || ss_n !== 1'b1) begin n_err++; $display("FAIL b2b_first: got cyc %0d ss_n %b want 197 1", dc, ss_n); end
    start_frame(24'h000001, 2'b00);
    wait_done(1'b0, dc, m1, me, s1, se, q1);
    n_vec++; if (q1 !== 1'b0) begin n_err++; $display("FAIL b2b_ss_gap: got ss_n %b on cycle after done want 0", q1); end
    n_vec++; if (dc != 197)   begin n_err++; $display("FAIL b2b_done_cyc: got %0d want 197", dc); end
    n_vec++; if (rx_data !== 24'hA5C33C) begin n_err++; $display("FAIL b2b_rx: got %h want a5c33c", rx_data); end
    n_vec++; if (chain_q !== 24'h000001) begin n_err++; $display("FAIL b2b_chain: got %h want 000001", chain_q); end
  endtask

  task automatic test_reset_abort();
    int dc; logic m1, me, s1, se, q1;
    int stray;
    preload(24'h777777);
    @(posedge clk); #1;
    start_frame(24'h3C3C3C, 2'b10);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_vec++; if (ss_n !== 1'b1)  begin n_err++; $display("FAIL abort_ss_n: got %b want 1", ss_n); end
    n_vec++; if (sclk !== 1'b0)  begin n_err++; $display("FAIL abort_sclk: got %b want 0", sclk); end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", ready); end
    n_vec++; if (rx_data !== '0) begin n_err++; $display("FAIL abort_rx: got %h want 0", rx_data); end
    stray = 0;
    preload(24'h0F0F0F);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) stray++;
    end
    rst = 1'b0;
    start_frame(24'h5A5A5A, 2'b00);
    wait_done(1'b0, dc, m1, me, s1, se, q1);
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL abort_no_done: got %0d done cycles want 0", stray); end
    n_vec++; if (dc != 197)  begin n_err++; $display("FAIL abort_next_cyc: got %0d want 197", dc); end
    n_vec++; if (rx_data !== 24'h0F0F0F) begin n_err++; $display("FAIL abort_next_rx: got %h want 0f0f0f", rx_data); end
    n_vec++; if (chain_q !== 24'h5A5A5A) begin n_err++; $display("FAIL abort_next_chain: got %h want 5a5a5a", chain_q); end
  endtask

  task automatic test_ignore_busy();
    int dc; logic m1, me, s1, se, q1;
    preload(24'hC0FFEE);
    @(posedge clk); #1;
    start_frame(24'h13579B, 2'b00);
    wait_done(1'b1, dc, m1, me, s1, se, q1);
    n_vec++; if (dc != 197) begin n_err++; $display("FAIL busy_done_cyc: got %0d want 197", dc); end
    n_vec++; if (rx_data !== 24'hC0FFEE) begin n_err++; $display("FAIL busy_rx: got %h want c0ffee", rx_data); end
    n_vec++; if (chain_q !== 24'h13579B) begin n_err++; $display("FAIL busy_chain: got %h want 13579b", chain_q); end
    @(posedge clk); #1;
    n_vec++; if (sclk !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL busy_idle: got sclk %b ready %b want 0 1", sclk, ready); end
    mode = 2'b00;
  endtask

  task automatic test_small_chain();
    int edges, first_e, last_e, gaps, dc;
    logic prev;
    edges = 0; first_e = -1; last_e = -1; gaps = 0; dc = -1;
    @(posedge clk); #1;
    s_tx    = 8'hFF;
    s_start = 1'b1;
    prev    = s_sclk;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      s_start = 1'b0;
      if (s_sclk !== prev) begin
        edges++;
        if (first_e < 0) first_e = c;
        else if (c - last_e != 1) gaps++;
        last_e = c;
      end
      prev = s_sclk;
      if (s_done) begin dc = c; break; end
    end
    n_vec++; if (edges != 16) begin n_err++; $display("FAIL small_edges: got %0d want 16", edges); end
    n_vec++; if (first_e != 2 || last_e != 17 || gaps != 0) begin n_err++; $display("FAIL small_spacing: got first %0d last %0d gaps %0d want 2 17 0", first_e, last_e, gaps); end
    n_vec++; if (dc != 18) begin n_err++; $display("FAIL small_done_cyc: got %0d want 18", dc); end
    n_vec++; if (s_rx !== 8'h00) begin n_err++; $display("FAIL small_rx: got %h want 00", s_rx); end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    mode    = 2'b00;
    tx_data = '0;
    s_start = 1'b0;
    s_mode  = 2'b00;
    s_tx    = '0;
    s_miso  = 1'b0;
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_reset_abort();
    test_ignore_busy();
    test_small_chain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_chain_master.md
SPI_CHAIN_MASTER -- requirements
Module: spi_chain_master

Interface
REQ-001 Parameter WIDTH, default 8: bits per chained device.
REQ-002 Parameter NUM_DEV, default 3: number of devices in the daisy chain; legal range 1..16.
REQ-003 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255.
REQ-004 Derived constant TOTAL = NUM_DEV*WIDTH: frame length in bits.
REQ-005 clk  input  1  single clock; all state is updated on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  transfer request, accepted only when ready=1.
REQ-008 mode  input  2  SPI mode {CPOL,CPHA}, sampled at start acceptance.
REQ-009 tx_data  input  TOTAL  outgoing frame; bits [TOTAL-1 -: WIDTH] target the last device in the chain.
REQ-010 ready  output  1  high when idle and able to accept start.
REQ-011 done  output  1  one-cycle pulse at the end of a frame.
REQ-012 rx_data  output  TOTAL  frame received on miso, MSB first; holds value until the next done.
REQ-013 sclk  output  1  serial clock.
REQ-014 mosi  output  1  serial data out to the first device in the chain.
REQ-015 miso  input  1  serial data in from the last device in the chain.
REQ-016 ss_n  output  1  chain select, active-low, shared by all devices.

Function
REQ-017 The FSM SHALL have the states IDLE, LEAD, SHIFT and TRAIL.
REQ-018 In IDLE with start=1 (cycle 0), the block SHALL latch tx_data and mode, drop ready, and enter LEAD with ss_n=0 from cycle 1.
REQ-019 In LEAD for CPHA=0, mosi SHALL present tx_data[TOTAL-1] from cycle 1.
REQ-020 sclk SHALL idle at CPOL and toggle every CLK_DIV cycles, with the first edge at cycle 1+CLK_DIV and 2*TOTAL edges in total.
REQ-021 For CPHA=0, the block SHALL sample miso on odd (leading) edges and shift mosi on even (trailing) edges, except after the final edge.
REQ-022 For CPHA=1, the block SHALL shift mosi on leading edges, with the first leading edge presenting the MSB, and sample miso on trailing edges.
REQ-023 After the last edge, the block SHALL wait one half-period in TRAIL.
REQ-024 At cycle 1+CLK_DIV*(2*TOTAL+1), ss_n, done and ready SHALL go high and rx_data SHALL update in that same cycle.
REQ-025 The FSM SHALL return to IDLE on the cycle in REQ-024.
REQ-026 A start asserted in the same cycle as done SHALL be accepted, giving back-to-back frames.
REQ-027 start, mode and tx_data changes SHALL be ignored while ready=0.
REQ-028 The bit counter SHALL be $clog2(TOTAL+1) bits wide.
REQ-029 The divider counter SHALL be $clog2(CLK_DIV+1) bits wide.
REQ-030 The bit and divider counters SHALL wrap only under FSM control and never free-run.
REQ-031 In IDLE, sclk SHALL follow the latched CPOL; a mode change SHALL take effect only at the next accepted start.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE, ready=1, done=0, ss_n=1, sclk=0, mosi=0, rx_data=0, latched mode=0, and all counters=0.
REQ-033 Reset mid-transfer SHALL abort the frame with no done pulse and leave rx_data at 0.
REQ-034 The first start SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-035 Package spi_pkg SHALL hold the mode typedef (2-bit struct {cpol,cpha}) and the FSM state enum.
REQ-036 Sub-module spi_clk_div SHALL generate the leading and trailing edge strobes and the sclk level from CLK_DIV and CPOL.
REQ-037 spi_clk_div SHALL be enabled only in the LEAD, SHIFT and TRAIL states.

Verification
REQ-038 Scenario 1: NUM_DEV=3, WIDTH=8, mode 0, tx_data=0xA5C33C, miso looped to mosi through a 24-bit shift-register chain model preloaded with 0x123456 -> rx_data=0x123456, model holds 0xA5C33C, done at cycle 1+4*49=197.
REQ-039 Scenario 2: run Scenario 1 in modes 1, 2 and 3 -> identical data results; sclk idle is 1 for modes 2 and 3; the first mosi change is on the first edge for CPHA=1.
REQ-040 Scenario 3: start asserted on the done cycle with a second frame 0x000001 -> ss_n high for exactly 1 cycle, and the second rx_data equals the first tx_data.
REQ-041 Scenario 4: rst pulsed at cycle 60 of a frame -> ss_n=1, sclk=0, ready=1 within the same cycle, no done pulse, and the next frame completes correctly.
REQ-042 Scenario 5: start and mode=3 toggled while busy -> ignored, and the frame completes in mode 0 with the same latency.
REQ-043 Scenario 6: CLK_DIV=1, NUM_DEV=1, WIDTH=8, tx_data=0xFF, miso tied 0 -> rx_data=0x00, 16 sclk edges at 1-cycle spacing, done at cycle 18.
